frame_acquisition: RTL and testbench

- Front-end stage sitting directly upstream of coherent_average_sm and lockin.
- Takes raw ADC samples plus a reference-period trigger, decimates by DECIM, and aligns the sample stream to the trigger.
- Emits a period-aligned Avalon-ST-style stream (x/x_valid) framed in periods of M samples, stopping after N_FRAMES frames, so that the coherent averager sees sample 0 exactly at the reference phase.

---
 rtl/frame_acq_pkg.sv | 13 +
 rtl/frame_acq_trig_edge.sv | 33 +++
 rtl/frame_acquisition.sv | 120 ++++++++++++
 tb/tb_frame_acquisition.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_acq_pkg.sv
// Shared types and sizing helpers for the frame_acquisition front end.
package frame_acq_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam int FRAMES_W = 16;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_acq_trig_edge.sv
// Reference-trigger rising-edge detector; `FRAME_ACQ_TRIG_SYNC_EN adds a
// two-flop synchronizer ahead of the edge register for an asynchronous trigger.
module frame_acq_trig_edge (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic trig_rise
);

    logic trig_s;
    logic trig_q;

`ifdef FRAME_ACQ_TRIG_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], trig};
    end

    assign trig_s = sync[1];
`else
    assign trig_s = trig;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) trig_q <= 1'b0;
        else       trig_q <= trig_s;
    end

    assign trig_rise = trig_s & ~trig_q;

endmodule

// File: rtl/frame_acquisition.sv
// Decimates ADC samples and frames them in M-sample periods aligned to the
// reference trigger. Optional macro: FRAME_ACQ_TRIG_SYNC_EN (trigger synchronizer).
module frame_acquisition
    import frame_acq_pkg::*;
#(
    parameter int M        = 128,
    parameter int DECIM    = 1,
    parameter int Q_ADC    = 14,
    parameter int Q_OUT    = 14,
    parameter int N_FRAMES = 8192
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [Q_ADC-1:0]    adc_data,
    input  logic                adc_valid,
    input  logic                trig,
    output logic [Q_OUT-1:0]    x,
    output logic                x_valid,
    output logic                sof,
    output logic [FRAMES_W-1:0] frames_done,
    output logic                acquiring,
    output logic                sync_error
);

    localparam int IDX_W = cnt_w(M);
    localparam int DEC_W = cnt_w(DECIM);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(M - 1);
    localparam logic [DEC_W-1:0]    DEC_LAST    = DEC_W'(DECIM - 1);
    localparam logic [FRAMES_W-1:0] FRAMES_LAST = FRAMES_W'(N_FRAMES - 1);

    state_t                    state;
    logic [IDX_W-1:0]          sample_idx;
    logic [DEC_W-1:0]          decim_cnt;
    logic                      trig_rise;
    logic                      aligned;
    logic signed [Q_OUT-1:0]   x_ext;

    frame_acq_trig_edge u_trig_edge (
        .clk       (clk),
        .reset     (reset),
        .trig      (trig),
        .trig_rise (trig_rise)
    );

    assign aligned = (sample_idx == '0) && (decim_cnt == '0);
    assign x_ext   = Q_OUT'($signed(adc_data));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            x           <= '0;
            x_valid     <= 1'b0;
            sof         <= 1'b0;
            frames_done <= '0;
            acquiring   <= 1'b0;
            sync_error  <= 1'b0;
            sample_idx  <= '0;
            decim_cnt   <= '0;
        end else begin
            x_valid <= 1'b0;
            sof     <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= ARM;
                        frames_done <= '0;
                        sync_error  <= 1'b0;
                        sample_idx  <= '0;
                        decim_cnt   <= '0;
                    end
                end
                ARM: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (trig_rise) begin
                        state      <= RUN;
                        acquiring  <= 1'b1;
                        sample_idx <= '0;
                        decim_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        acquiring <= 1'b0;
                    end else if (trig_rise && !aligned) begin
                        // Re-anchor to the trigger; a sample arriving now is dropped.
                        sync_error <= 1'b1;
                        sample_idx <= '0;
                        decim_cnt  <= '0;
                    end else if (adc_valid) begin
                        decim_cnt <= (decim_cnt == DEC_LAST) ? '0 : decim_cnt + 1'b1;
                        if (decim_cnt == '0) begin
                            x       <= x_ext;
                            x_valid <= 1'b1;
                            sof     <= (sample_idx == '0);
                            if (sample_idx == IDX_LAST) begin
                                sample_idx <= '0;
                                if (frames_done != '1)
                                    frames_done <= frames_done + 1'b1;
                                if (N_FRAMES > 0 && frames_done == FRAMES_LAST) begin
                                    state     <= DONE;
                                    acquiring <= 1'b0;
                                end
                            end else begin
                                sample_idx <= sample_idx + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!enable) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_acquisition.sv
// Bench for frame_acquisition: two configurations driven in parallel, directed
// sequences plus randomized traffic checked against a counting reference model.
module tb_frame_acquisition;

`ifdef FRAME_ACQ_TRIG_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    // Clock edges from the trigger rising to acquiring being observed high.
    localparam int LAT = SYNC ? 3 : 1;

    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        adc_valid = 1'b0;
    logic        trig = 1'b0;
    logic [13:0] adc_data = '0;

    logic [26:0] a_x;
    logic        a_xv, a_sof, a_acq, a_se;
    logic [15:0] a_fd;
    logic [13:0] b_x;
    logic        b_xv, b_sof, b_acq, b_se;
    logic [15:0] b_fd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frame_acquisition #(.M(8), .DECIM(1), .Q_ADC(14), .Q_OUT(27), .N_FRAMES(2)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .adc_data(adc_data),
        .adc_valid(adc_valid), .trig(trig), .x(a_x), .x_valid(a_xv), .sof(a_sof),
        .frames_done(a_fd), .acquiring(a_acq), .sync_error(a_se)
    );

    frame_acquisition #(.M(8), .DECIM(4), .Q_ADC(14), .Q_OUT(14), .N_FRAMES(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .adc_data(adc_data),
        .adc_valid(adc_valid), .trig(trig), .x(b_x), .x_valid(b_xv), .sof(b_sof),
        .frames_done(b_fd), .acquiring(b_acq), .sync_error(b_se)
    );

    // Reference model: k counts accepted samples since the last phase anchor.
    typedef struct {
        int          mode;
        int          k;
        int          frames;
        bit          serr;
        logic [26:0] x;
        bit          xv;
        bit          sof;
        bit          acq;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t r;
        r.mode = M_IDLE; r.k = 0; r.frames = 0; r.serr = 0;
        r.x = '0; r.xv = 0; r.sof = 0; r.acq = 0;
        return r;
    endfunction

    function automatic logic [26:0] sext(logic [13:0] a, int q);
        logic [26:0] v = 27'($signed(a));
        if (q < 27) v = v & ((27'd1 << q) - 27'd1);
        return v;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int m, int d, int n, int q,
                                   bit en, bit av, logic [13:0] ad, bit e);
        mdl_t r = s;
        int   f;
        r.xv  = 0;
        r.sof = 0;
        case (s.mode)
            M_IDLE: if (en) begin r.mode = M_ARM; r.frames = 0; r.serr = 0; end
            M_ARM: begin
                if (!en) r.mode = M_IDLE;
                else if (e) begin r.mode = M_RUN; r.k = 0; end
            end
            M_RUN: begin
                if (!en) r.mode = M_IDLE;
                else if (e && (s.k % (d * m)) != 0) begin r.serr = 1; r.k = 0; end
                else if (av) begin
                    if (s.k % d == 0) begin
                        f     = (s.k / d) % m;
                        r.xv  = 1;
                        r.x   = sext(ad, q);
                        r.sof = (f == 0);
                        if (f == m - 1) begin
                            if (r.frames < 65535) r.frames++;
                            if (n > 0 && r.frames == n) r.mode = M_DONE;
                        end
                    end
                    r.k = s.k + 1;
                end
            end
            default: if (!en) r.mode = M_IDLE;
        endcase
        r.acq = (r.mode == M_RUN);
        return r;
    endfunction

    mdl_t       ma = mreset();
    mdl_t       mb = mreset();
    logic [3:1] tp = '0;   // trig seen at the previous 1..3 clock edges

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= mreset();
            mb <= mreset();
            tp <= '0;
        end else begin
            bit e;
            e = SYNC ? (tp[2] & ~tp[3]) : (trig & ~tp[1]);
            ma <= mstep(ma, 8, 1, 2, 27, enable, adc_valid, adc_data, e);
            mb <= mstep(mb, 8, 4, 0, 14, enable, adc_valid, adc_data, e);
            tp <= {tp[2:1], trig};
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input logic [26:0] x, input logic xv, input logic sf,
                       input logic [15:0] fd, input logic acq, input logic se, input mdl_t e);
        tests++;
        if ({x, xv, sf, fd, acq, se} !== {e.x, e.xv, e.sof, 16'(e.frames), e.acq, e.serr}) begin
            fails++;
            $display("FAIL %s @%0t: got x=%h v=%b sof=%b fd=%0d acq=%b se=%b expected x=%h v=%b sof=%b fd=%0d acq=%b se=%b",
                     nm, $time, x, xv, sf, fd, acq, se, e.x, e.xv, e.sof, e.frames, e.acq, e.serr);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp("model_a", a_x, a_xv, a_sof, a_fd, a_acq, a_se, ma);
            cmp("model_b", b_x, b_xv, b_sof, b_fd, b_acq, b_se, mb);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_run();
        enable = 0; adc_valid = 0; trig = 0;
        cyc(4);
        enable = 1;
        cyc(1);
        check("arm_cleared", {a_fd, a_se, a_acq}, '0);
        trig = 1;
        cyc(LAT);
        trig = 0;
        check("run_entered", {a_acq, b_acq}, 2'b11);
    endtask

    typedef struct {
        logic [13:0] d;
        logic [26:0] x;
        bit          sof;
        int          fd;
    } vec_t;

    vec_t tv[16];
    int   lat;

    initial begin
        tv[0] = '{14'h2000, 27'h7FFE000, 1'b1, 0};
        tv[1] = '{14'h1FFF, 27'h0001FFF, 1'b0, 0};
        tv[2] = '{14'h3FFF, 27'h7FFFFFF, 1'b0, 0};
        tv[3] = '{14'h0000, 27'h0000000, 1'b0, 0};
        tv[4] = '{14'h0001, 27'h0000001, 1'b0, 0};
        tv[5] = '{14'h2001, 27'h7FFE001, 1'b0, 0};
        for (int i = 6; i < 16; i++)
            tv[i] = '{14'(i), 27'(i), (i == 8), (i == 15) ? 2 : ((i >= 7) ? 1 : 0)};

        #1 reset = 1;
        cyc(3);
        check("reset_a", {a_x, a_xv, a_sof, a_fd, a_acq, a_se}, '0);
        check("reset_b", {b_x, b_xv, b_sof, b_fd, b_acq, b_se}, '0);
        reset = 0;
        cyc(2);
        check("idle_acq", a_acq, 0);

        // Arm, then measure edge-to-RUN latency.
        enable = 1;
        cyc(1);
        trig = 1;
        lat = 0;
        while (lat < 6 && !a_acq) begin
            cyc(1);
            lat++;
        end
        check("trig_latency", lat, LAT);
        trig = 0;

        // Two full frames of M=8: sign extension, sof placement, frame count.
        for (int i = 0; i < 16; i++) begin
            adc_valid = 1;
            adc_data  = tv[i].d;
            cyc(1);
            check($sformatf("tv%0d_x", i), a_x, tv[i].x);
            check($sformatf("tv%0d_vsof", i), {a_xv, a_sof}, {1'b1, tv[i].sof});
            check($sformatf("tv%0d_fd", i), a_fd, tv[i].fd);
        end
        for (int i = 0; i < 3; i++) begin
            adc_data = 14'(100 + i);
            cyc(1);
            check("done_quiet", {a_xv, a_acq, a_fd}, {2'b00, 16'd2});
        end

        // Decimate-by-4 ramp.
        arm_run();
        for (int i = 0; i < 16; i++) begin
            adc_valid = 1;
            adc_data  = 14'(i);
            cyc(1);
            if (i % 4 == 0) check($sformatf("dec_%0d", i), {b_xv, b_sof, b_x}, {1'b1, (i == 0), 14'(i)});
            else            check($sformatf("dec_%0d", i), b_xv, 0);
        end

        // Misaligned trigger at sample index 3, coinciding with a sample.
        arm_run();
        for (int i = 0; i < 3; i++) begin
            adc_valid = 1;
            adc_data  = 14'(10 + i);
            cyc(1);
        end
        trig = 1;
        adc_valid = 0;
        cyc(LAT - 1);
        adc_valid = 1;
        adc_data  = 14'd99;
        cyc(1);
        check("mis_drop", {a_xv, a_se}, 2'b01);
        trig = 0;
        adc_data = 14'd50;
        cyc(1);
        check("mis_resync", {a_xv, a_sof, a_x}, {2'b11, 27'd50});
        check("mis_fd", a_fd, 0);

        // Enable dropped mid-frame, then re-armed.
        adc_data = 14'd51; cyc(1);
        adc_data = 14'd52; cyc(1);
        enable = 0;
        cyc(1);
        check("dis_stop", {a_xv, a_acq}, 2'b00);
        cyc(1);
        check("dis_hold", {a_xv, a_se, a_fd}, {2'b01, 16'd0});
        arm_run();
        adc_valid = 1;
        adc_data  = 14'd7;
        cyc(1);
        check("rearm_sof", {a_xv, a_sof, a_x}, {2'b11, 27'd7});

        // Asynchronous reset between clock edges.
        cyc(3);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check("async_rst_a", {a_x, a_xv, a_sof, a_fd, a_acq, a_se}, '0);
        check("async_rst_b", {b_x, b_xv, b_sof, b_fd, b_acq, b_se}, '0);
        @(negedge clk);
        reset = 0;
        cyc(3);
        check("post_rst_idle", {a_acq, a_xv, b_acq, b_xv}, '0);

        // Randomized traffic against the model.
        arm_run();
        for (int i = 0; i < 4000; i++) begin
            enable    = ($urandom_range(0, 299) != 0);
            adc_valid = ($urandom_range(0, 3) != 0);
            adc_data  = 14'($urandom);
            trig      = ($urandom_range(0, 47) == 0);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
